// File: rtl/switch_pkg.sv
// Shared widths, reset defaults and FSM states for the switch phase sequencer.
// cfg_ok holds the config validity rule, evaluated one bit wider than CNT_W.
package switch_pkg;

   localparam int CNT_W   = 16;
   localparam int DEAD_W  = 8;
   localparam int BURST_W = 16;

   localparam logic [CNT_W-1:0]  DEF_PERIOD = 16'd48000;
   localparam logic [CNT_W-1:0]  DEF_HIGH   = 16'd24000;
   localparam logic [DEAD_W-1:0] DEF_DEAD   = 8'd0;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      LAST
   } state_t;

   function automatic logic [CNT_W:0] dead_ext(
      input logic [DEAD_W-1:0] d
   );
      return {{(CNT_W+1-DEAD_W){1'b0}}, d};
   endfunction

   // H + 2*D needs the extra bit so a large H cannot wrap into a legal value
   function automatic logic cfg_ok(
      input logic [CNT_W-1:0]  p,
      input logic [CNT_W-1:0]  h,
      input logic [DEAD_W-1:0] d
   );
      logic [CNT_W:0] sum;
      sum = {1'b0, h} + (dead_ext(d) << 1);
      return (p >= CNT_W'(4)) && (h != '0) && (sum < {1'b0, p});
   endfunction

endpackage

// File: rtl/switch_cfg_shadow.sv
// Config handshake: validity check, error pulse, shadow register and
// boundary-aligned transfer into the active period/high/dead set.
module switch_cfg_shadow
   import switch_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_valid,
   input  logic [CNT_W-1:0]  cfg_period,
   input  logic [CNT_W-1:0]  cfg_high,
   input  logic [DEAD_W-1:0] cfg_dead,
   input  logic              running,
   input  logic              boundary,
   output logic              cfg_ready,
   output logic              cfg_err,
   output logic [CNT_W-1:0]  period,
   output logic [CNT_W-1:0]  next_period,
   output logic [CNT_W-1:0]  next_high,
   output logic [DEAD_W-1:0] next_dead
);

   logic [CNT_W-1:0]  high;
   logic [DEAD_W-1:0] dead;
   logic [CNT_W-1:0]  sh_period;
   logic [CNT_W-1:0]  sh_high;
   logic [DEAD_W-1:0] sh_dead;
   logic              full;
   logic              take;
   logic              good;
   logic              copy;

   assign cfg_ready = !full;
   assign take      = cfg_valid && cfg_ready;
   assign good      = cfg_ok(cfg_period, cfg_high, cfg_dead);
   // a shadow left over when a run ends is flushed on the first idle cycle
   assign copy      = full && (boundary || !running);

   always_comb begin
      next_period = period;
      next_high   = high;
      next_dead   = dead;
      if (!running && take && good) begin
         next_period = cfg_period;
         next_high   = cfg_high;
         next_dead   = cfg_dead;
      end else if (copy) begin
         next_period = sh_period;
         next_high   = sh_high;
         next_dead   = sh_dead;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         period    <= DEF_PERIOD;
         high      <= DEF_HIGH;
         dead      <= DEF_DEAD;
         sh_period <= '0;
         sh_high   <= '0;
         sh_dead   <= '0;
         full      <= 1'b0;
         cfg_err   <= 1'b0;
      end else begin
         period  <= next_period;
         high    <= next_high;
         dead    <= next_dead;
         cfg_err <= take && !good;
         if (copy) begin
            full <= 1'b0;
         end else if (running && take && good) begin
            sh_period <= cfg_period;
            sh_high   <= cfg_high;
            sh_dead   <= cfg_dead;
            full      <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/switch_phase_sequencer.sv
// Complementary switch drive with dead time, burst/continuous run control
// and a sample strobe at the centre of the A phase.
module switch_phase_sequencer
   import switch_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [CNT_W-1:0]   cfg_period,
   input  logic [CNT_W-1:0]   cfg_high,
   input  logic [DEAD_W-1:0]  cfg_dead,
   output logic               cfg_err,
   input  logic               start,
   input  logic               stop,
   input  logic [BURST_W-1:0] burst_len,
   output logic               sw_a,
   output logic               sw_b,
   output logic               sample_stb,
   output logic               busy,
   output logic               done
);

   state_t             state;
   state_t             nstate;
   logic [CNT_W-1:0]   k;
   logic [CNT_W-1:0]   nk;
   logic [BURST_W-1:0] rem;
   logic [BURST_W-1:0] nrem;
   logic               ndone;
   logic               running;
   logic               boundary;
   logic               live;
   logic [CNT_W-1:0]   period;
   logic [CNT_W-1:0]   next_period;
   logic [CNT_W-1:0]   next_high;
   logic [DEAD_W-1:0]  next_dead;
   logic [CNT_W:0]     b_lo;
   logic [CNT_W:0]     b_hi;
   logic [CNT_W:0]     kx;
   logic               na;
   logic               nb;
   logic               ns;

   assign running  = (state != IDLE);
   assign boundary = running && (k == period - CNT_W'(1));

   switch_cfg_shadow u_cfg (
      .clk         (clk),
      .rst         (rst),
      .cfg_valid   (cfg_valid),
      .cfg_period  (cfg_period),
      .cfg_high    (cfg_high),
      .cfg_dead    (cfg_dead),
      .running     (running),
      .boundary    (boundary),
      .cfg_ready   (cfg_ready),
      .cfg_err     (cfg_err),
      .period      (period),
      .next_period (next_period),
      .next_high   (next_high),
      .next_dead   (next_dead)
   );

   always_comb begin
      nstate = state;
      nk     = k;
      nrem   = rem;
      ndone  = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               nstate = RUN;
               nk     = '0;
               nrem   = burst_len;
            end
         end
         RUN, LAST: begin
            if (boundary) begin
               nk = '0;
               if (rem != '0) nrem = rem - BURST_W'(1);
               // burst end wins over a coincident stop: one done pulse
               if (state == LAST || rem == BURST_W'(1)) begin
                  nstate = IDLE;
                  ndone  = 1'b1;
               end else if (rem == BURST_W'(2) || stop) begin
                  nstate = LAST;
               end
            end else begin
               nk = k + CNT_W'(1);
               if (state == RUN && stop) nstate = LAST;
            end
         end
         default: nstate = IDLE;
      endcase
   end

   assign live = (nstate != IDLE);
   assign kx   = {1'b0, nk};
   assign b_lo = {1'b0, next_high} + dead_ext(next_dead);
   assign b_hi = {1'b0, next_period} - dead_ext(next_dead);

   always_comb begin
      na = live && (nk < next_high);
      nb = live && (b_lo <= kx) && (kx < b_hi);
      ns = live && (nk == (next_high >> 1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         k          <= '0;
         rem        <= '0;
         sw_a       <= 1'b0;
         sw_b       <= 1'b0;
         sample_stb <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= nstate;
         k          <= nk;
         rem        <= nrem;
         sw_a       <= na;
         sw_b       <= nb;
         sample_stb <= ns;
         busy       <= live;
         done       <= ndone;
      end
   end

endmodule

// File: tb/tb_switch_phase_sequencer.sv
// Directed bench for switch_phase_sequencer: config table, waveform table
// and hand-written sequences for stop, reset and burst corner cases.
module tb_switch_phase_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [15:0] cfg_period;
   logic [15:0] cfg_high;
   logic [7:0]  cfg_dead;
   logic        cfg_err;
   logic        start;
   logic        stop;
   logic [15:0] burst_len;
   logic        sw_a;
   logic        sw_b;
   logic        sample_stb;
   logic        busy;
   logic        done;

   int passed = 0;
   int total  = 0;

   typedef struct {
      int p;
      int h;
      int d;
      int err;
   } cfg_vec_t;

   typedef struct {
      int k;
      int a;
      int b;
      int s;
   } wav_vec_t;

   cfg_vec_t cv[7];
   wav_vec_t wv[9];
   logic     la[300];
   logic     lb[300];
   logic     ls[300];

   always #5 clk = ~clk;

   switch_phase_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_period (cfg_period),
      .cfg_high   (cfg_high),
      .cfg_dead   (cfg_dead),
      .cfg_err    (cfg_err),
      .start      (start),
      .stop       (stop),
      .burst_len  (burst_len),
      .sw_a       (sw_a),
      .sw_b       (sw_b),
      .sample_stb (sample_stb),
      .busy       (busy),
      .done       (done)
   );

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d want %0d", nm, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      repeat (n) step();
   endtask

   task automatic offer(input int p, input int h, input int d);
      cfg_period = 16'(p);
      cfg_high   = 16'(h);
      cfg_dead   = 8'(d);
      cfg_valid  = 1'b1;
      step();
      cfg_valid  = 1'b0;
   endtask

   task automatic go(input int blen);
      burst_len = 16'(blen);
      start     = 1'b1;
      step();
      start     = 1'b0;
   endtask

   task automatic wait_done(input string nm, input int budget);
      int seen;
      seen = 0;
      for (int i = 0; i < budget; i++) begin
         step();
         if (done) begin
            seen = 1;
            break;
         end
      end
      chk(nm, seen, 1);
   endtask

   initial begin
      int ca;
      int cb;
      int cs;
      int sk;
      int extra;

      cv[0] = '{3, 1, 0, 1};
      cv[1] = '{10, 0, 0, 1};
      cv[2] = '{65535, 65535, 255, 1};
      cv[3] = '{65535, 65000, 255, 0};
      cv[4] = '{4, 1, 1, 0};
      cv[5] = '{100, 40, 5, 0};
      cv[6] = '{10, 4, 3, 1};

      wv[0] = '{0, 1, 0, 0};
      wv[1] = '{20, 1, 0, 1};
      wv[2] = '{39, 1, 0, 0};
      wv[3] = '{40, 0, 0, 0};
      wv[4] = '{44, 0, 0, 0};
      wv[5] = '{45, 0, 1, 0};
      wv[6] = '{94, 0, 1, 0};
      wv[7] = '{95, 0, 0, 0};
      wv[8] = '{99, 0, 0, 0};

      rst        = 1'b1;
      cfg_valid  = 1'b0;
      cfg_period = '0;
      cfg_high   = '0;
      cfg_dead   = '0;
      start      = 1'b0;
      stop       = 1'b0;
      burst_len  = '0;
      steps(3);
      rst = 1'b0;
      chk("rst_sw_a", sw_a, 0);
      chk("rst_sw_b", sw_b, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ready", cfg_ready, 1);
      chk("rst_err", cfg_err, 0);
      step();

      // config validity table; last entry is invalid and must not stick
      for (int i = 0; i < 7; i++) begin
         offer(cv[i].p, cv[i].h, cv[i].d);
         chk($sformatf("cfg%0d_err", i), cfg_err, cv[i].err);
         chk($sformatf("cfg%0d_ready", i), cfg_ready, 1);
         step();
         chk($sformatf("cfg%0d_err_off", i), cfg_err, 0);
      end

      // burst of 3 periods at P=100 H=40 D=5
      go(3);
      for (int n = 0; n < 300; n++) begin
         if (n > 0) step();
         la[n] = sw_a;
         lb[n] = sw_b;
         ls[n] = sample_stb;
      end
      chk("b3_done_early", done, 0);
      chk("b3_busy_last", busy, 1);
      for (int i = 0; i < 9; i++) begin
         chk($sformatf("b3_a_k%0d", wv[i].k), la[wv[i].k], wv[i].a);
         chk($sformatf("b3_b_k%0d", wv[i].k), lb[wv[i].k], wv[i].b);
         chk($sformatf("b3_s_k%0d", wv[i].k), ls[wv[i].k], wv[i].s);
         chk($sformatf("b3_a2_k%0d", wv[i].k), la[200+wv[i].k], wv[i].a);
         chk($sformatf("b3_b2_k%0d", wv[i].k), lb[200+wv[i].k], wv[i].b);
      end
      ca = 0;
      cb = 0;
      cs = 0;
      for (int n = 0; n < 300; n++) begin
         ca += int'(la[n]);
         cb += int'(lb[n]);
         cs += int'(ls[n]);
      end
      chk("b3_a_cnt", ca, 120);
      chk("b3_b_cnt", cb, 150);
      chk("b3_s_cnt", cs, 3);
      step();
      chk("b3_done", done, 1);
      chk("b3_busy_end", busy, 0);
      chk("b3_a_end", sw_a, 0);
      chk("b3_b_end", sw_b, 0);
      step();
      chk("b3_done_once", done, 0);

      // mid-run reconfig: old waveform until the boundary
      go(0);
      steps(10);
      offer(200, 100, 0);
      chk("mr_ready_lo", cfg_ready, 0);
      steps(29);
      chk("mr_old_a_k40", sw_a, 0);
      chk("mr_ready_k40", cfg_ready, 0);
      steps(59);
      chk("mr_ready_k99", cfg_ready, 0);
      chk("mr_old_b_k99", sw_b, 0);
      step();
      chk("mr_new_a_k0", sw_a, 1);
      chk("mr_ready_hi", cfg_ready, 1);
      steps(50);
      chk("mr_new_s_k50", sample_stb, 1);
      steps(49);
      chk("mr_new_a_k99", sw_a, 1);
      step();
      chk("mr_new_a_k100", sw_a, 0);
      chk("mr_new_b_k100", sw_b, 1);
      steps(99);
      chk("mr_new_b_k199", sw_b, 1);
      step();
      chk("mr_wrap_a", sw_a, 1);
      chk("mr_wrap_b", sw_b, 0);
      stop = 1'b1;
      step();
      stop = 1'b0;
      wait_done("mr_stop_done", 300);
      step();
      chk("mr_busy_off", busy, 0);

      // graceful stop at k=20 of P=100
      offer(100, 40, 5);
      chk("st_cfg_err", cfg_err, 0);
      go(0);
      steps(20);
      stop = 1'b1;
      step();
      stop = 1'b0;
      steps(9);
      chk("st_a_k30", sw_a, 1);
      chk("st_busy_k30", busy, 1);
      steps(69);
      chk("st_done_k99", done, 0);
      chk("st_busy_k99", busy, 1);
      step();
      chk("st_done", done, 1);
      chk("st_busy", busy, 0);
      chk("st_a", sw_a, 0);
      chk("st_b", sw_b, 0);
      step();
      chk("st_done_once", done, 0);

      // start and stop together in IDLE: start wins
      start = 1'b1;
      stop  = 1'b1;
      burst_len = '0;
      step();
      start = 1'b0;
      stop  = 1'b0;
      chk("ss_busy", busy, 1);
      chk("ss_a", sw_a, 1);
      stop = 1'b1;
      step();
      stop = 1'b0;
      wait_done("ss_done", 150);
      step();

      // single-period burst ending on the same edge as stop
      go(1);
      steps(99);
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("bs_done", done, 1);
      chk("bs_busy", busy, 0);
      extra = 0;
      for (int i = 0; i < 150; i++) begin
         step();
         extra += int'(done);
      end
      chk("bs_extra_done", extra, 0);

      // reset mid-run discards pending config and restores defaults
      go(0);
      steps(10);
      offer(60, 30, 0);
      chk("rr_ready_lo", cfg_ready, 0);
      steps(39);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rr_a", sw_a, 0);
      chk("rr_b", sw_b, 0);
      chk("rr_busy", busy, 0);
      chk("rr_ready", cfg_ready, 1);

      // default 48000-cycle waveform
      go(0);
      ca = 0;
      cb = 0;
      cs = 0;
      sk = -1;
      for (int n = 0; n < 48000; n++) begin
         if (n > 0) step();
         ca += int'(sw_a);
         cb += int'(sw_b);
         if (sample_stb) begin
            cs++;
            sk = n;
         end
         if (n == 23999) chk("df_a_k23999", sw_a, 1);
         if (n == 24000) chk("df_a_k24000", sw_a, 0);
      end
      chk("df_a_cnt", ca, 24000);
      chk("df_b_cnt", cb, 24000);
      chk("df_s_cnt", cs, 1);
      chk("df_s_k", sk, 12000);
      step();
      chk("df_wrap_a", sw_a, 1);
      chk("df_wrap_b", sw_b, 0);
      rst = 1'b1;
      step();
      rst = 1'b0;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
